// File: rtl/register_bank_reader_if.sv
// Bus bundle for register_bank_reader: write port, read request/ack handshake
// and status flags. The consumer side uses the master modport.
interface register_bank_reader_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              w;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  d;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_busy;
    logic              overrun;
    logic [1:0]        dbg_state;

    modport slave (
        input  w, w_addr, d, rd_req, rd_addr, rd_ack,
        output rd_data, rd_valid, rd_busy, overrun, dbg_state
    );

    modport master (
        output w, w_addr, d, rd_req, rd_addr, rd_ack,
        input  rd_data, rd_valid, rd_busy, overrun, dbg_state
    );
endinterface

// File: rtl/register_bank_reader.sv
// Register bank with a single-outstanding registered read port. All state
// changes on the falling clock edge; reset is synchronous and active-high.
module register_bank_reader #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input logic                   clk,
    input logic                   reset,
    register_bank_reader_if.slave bus
);
    // Read handshake: rd_req is taken only in IDLE; rd_data/rd_valid then stay
    // frozen until an edge sees rd_ack=1 while valid, which returns to IDLE.
    // A request seen while busy is dropped and recorded in the sticky overrun.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic              rd_valid_q;
    logic              overrun_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.rd_req) state_n = READ;
            READ:    state_n = HOLD;
            HOLD:    if (bus.rd_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state <= state_n;
            if (bus.w) regs[bus.w_addr] <= bus.d;

            if (state == IDLE && bus.rd_req) addr_q <= bus.rd_addr;

            // A write landing on the same edge as the fetch is forwarded.
            if (state == READ) begin
                rd_data_q  <= (bus.w && bus.w_addr == addr_q) ? bus.d : regs[addr_q];
                rd_valid_q <= 1'b1;
            end

            if (state == HOLD && bus.rd_ack) rd_valid_q <= 1'b0;

            if (state != IDLE && bus.rd_req) overrun_q <= 1'b1;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_busy   = (state != IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.dbg_state = state;
endmodule
